// File: rtl/mnv3_acc_pkg.sv
// rtl/mnv3_acc_pkg.sv - shared encodings, FSM states and constants for psum_accumulator
package mnv3_acc_pkg;

    localparam int DEF_DATA_WIDTH = 12;
    localparam int DEF_FRAC_WIDTH = 5;
    localparam int DEF_ACC_WIDTH  = 20;
    localparam int DEF_MAX_PSUMS  = 255;

    localparam logic [1:0] ACT_NONE   = 2'b00;
    localparam logic [1:0] ACT_RELU   = 2'b01;
    localparam logic [1:0] ACT_RELU6  = 2'b10;
    localparam logic [1:0] ACT_HSWISH = 2'b11;

    // Q7.5 constants: 6.0, 3.0 and 1/6 in Q0.10
    localparam int RELU6_MAX     = 192;
    localparam int HSWISH_OFFSET = 96;
    localparam int ONE_SIXTH_Q10 = 171;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/act_unit.sv
// rtl/act_unit.sv - activation and output saturation stage; PSUM_ACCUMULATOR_HSWISH_EN adds
// hard-swish on act_sel=11 behind one extra register
module act_unit
    import mnv3_acc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_WIDTH = DEF_FRAC_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    input  logic signed [ACC_WIDTH-1:0] in_acc,
    input  logic [1:0]                  in_act,
    input  logic [7:0]                  in_count,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        data_valid_out,
    output logic                        sat_flag,
    output logic [7:0]                  psum_count
);

    // Headroom for the hard-swish product chain (acc * t * 171)
    localparam int RES_W = ACC_WIDTH + 24;
    localparam logic signed [RES_W-1:0] RELU6_LIM =
        RES_W'((longint'(RELU6_MAX) <<< FRAC_WIDTH) >>> DEF_FRAC_WIDTH);
    localparam logic signed [RES_W-1:0] SAT_HI = RES_W'((longint'(1) <<< (DATA_WIDTH - 1)) - 1);
    localparam logic signed [RES_W-1:0] SAT_LO = -SAT_HI - 1;

    logic signed [RES_W-1:0] acc_x;
    logic signed [RES_W-1:0] act_val;
    logic signed [RES_W-1:0] sat_in_val;
    logic                    sat_in_valid;
    logic [7:0]              sat_in_count;
    logic [DATA_WIDTH-1:0]   sat_word;
    logic                    sat_hit;

    assign acc_x = RES_W'(in_acc);

`ifdef PSUM_ACCUMULATOR_HSWISH_EN
    localparam int HS_SHIFT = 10 + FRAC_WIDTH;
    localparam logic signed [RES_W-1:0] HS_OFF =
        RES_W'((longint'(HSWISH_OFFSET) <<< FRAC_WIDTH) >>> DEF_FRAC_WIDTH);
    localparam logic signed [RES_W-1:0] HS_ROUND = RES_W'(longint'(1) <<< (HS_SHIFT - 1));

    logic signed [RES_W-1:0] hs_sum;
    logic signed [RES_W-1:0] hs_t;
    logic signed [RES_W-1:0] hs_prod;
    logic signed [RES_W-1:0] hswish_val;

    always_comb begin
        hs_sum = acc_x + HS_OFF;
        if (hs_sum < 0) begin
            hs_t = '0;
        end else if (hs_sum > RELU6_LIM) begin
            hs_t = RELU6_LIM;
        end else begin
            hs_t = hs_sum;
        end
        hs_prod    = acc_x * hs_t * RES_W'(ONE_SIXTH_Q10);
        hswish_val = (hs_prod + HS_ROUND) >>> HS_SHIFT;
    end
`endif

    always_comb begin
        act_val = acc_x;
        case (in_act)
            ACT_RELU:  act_val = (acc_x < 0) ? '0 : acc_x;
            ACT_RELU6: begin
                if (acc_x < 0) begin
                    act_val = '0;
                end else if (acc_x > RELU6_LIM) begin
                    act_val = RELU6_LIM;
                end else begin
                    act_val = acc_x;
                end
            end
`ifdef PSUM_ACCUMULATOR_HSWISH_EN
            ACT_HSWISH: act_val = hswish_val;
`endif
            default:   act_val = acc_x;
        endcase
    end

`ifdef PSUM_ACCUMULATOR_HSWISH_EN
    logic signed [RES_W-1:0] mid_val;
    logic                    mid_valid;
    logic [7:0]              mid_count;

    // Every act_sel goes through this register so latency does not depend on the mode
    always_ff @(posedge clk) begin
        if (reset) begin
            mid_val   <= '0;
            mid_valid <= 1'b0;
            mid_count <= '0;
        end else begin
            mid_valid <= in_valid & ~flush;
            if (in_valid) begin
                mid_val   <= act_val;
                mid_count <= in_count;
            end
        end
    end

    assign sat_in_val   = mid_val;
    assign sat_in_valid = mid_valid;
    assign sat_in_count = mid_count;
`else
    assign sat_in_val   = act_val;
    assign sat_in_valid = in_valid;
    assign sat_in_count = in_count;
`endif

    always_comb begin
        sat_hit = 1'b1;
        if (sat_in_val > SAT_HI) begin
            sat_word = DATA_WIDTH'(SAT_HI);
        end else if (sat_in_val < SAT_LO) begin
            sat_word = DATA_WIDTH'(SAT_LO);
        end else begin
            sat_hit  = 1'b0;
            sat_word = sat_in_val[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out       <= '0;
            data_valid_out <= 1'b0;
            sat_flag       <= 1'b0;
            psum_count     <= '0;
        end else begin
            data_valid_out <= sat_in_valid & ~flush;
            if (sat_in_valid & ~flush) begin
                data_out   <= sat_word;
                sat_flag   <= sat_hit;
                psum_count <= sat_in_count;
            end
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - groups adder-tree partial sums with bias, then activates and saturates;
// PSUM_ACCUMULATOR_HSWISH_EN enables hard-swish
module psum_accumulator
    import mnv3_acc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_WIDTH = DEF_FRAC_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int MAX_PSUMS  = DEF_MAX_PSUMS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_valid_in,
    input  logic [DATA_WIDTH-1:0] psum_in,
    input  logic                  last_in,
    input  logic [DATA_WIDTH-1:0] bias_in,
    input  logic [1:0]            act_sel,
    input  logic                  end_flag,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid_out,
    output logic                  sat_flag,
    output logic [7:0]            psum_count
);

    state_t                  state, state_n;
    logic signed [ACC_WIDTH-1:0] psum_ext, bias_ext;
    logic signed [ACC_WIDTH-1:0] acc, acc_n, snap_acc;
    logic [7:0]              count, count_n, snap_count;
    logic [1:0]              act_lat, act_n, snap_act;
    logic                    snap, snap_valid;

    assign psum_ext = ACC_WIDTH'($signed(psum_in));
    assign bias_ext = ACC_WIDTH'($signed(bias_in));

    always_comb begin
        state_n = state;
        acc_n   = acc;
        count_n = count;
        act_n   = act_lat;
        snap    = 1'b0;
        if (data_valid_in) begin
            if (state == ST_ACCUM) begin
                acc_n   = acc + psum_ext;
                count_n = count + 8'd1;
                if (last_in || count_n == 8'(MAX_PSUMS)) begin
                    state_n = ST_FINISH;
                    snap    = 1'b1;
                end
            end else begin
                // IDLE and FINISH both open a new group, so groups can run back to back
                acc_n   = bias_ext + psum_ext;
                count_n = 8'd1;
                act_n   = act_sel;
                if (last_in || MAX_PSUMS <= 1) begin
                    state_n = ST_FINISH;
                    snap    = 1'b1;
                end else begin
                    state_n = ST_ACCUM;
                end
            end
        end else if (state == ST_FINISH) begin
            state_n = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            acc        <= '0;
            count      <= '0;
            act_lat    <= ACT_NONE;
            snap_valid <= 1'b0;
            snap_acc   <= '0;
            snap_count <= '0;
            snap_act   <= ACT_NONE;
        end else if (end_flag) begin
            state      <= ST_IDLE;
            acc        <= '0;
            count      <= '0;
            snap_valid <= 1'b0;
        end else begin
            state      <= state_n;
            acc        <= acc_n;
            count      <= count_n;
            act_lat    <= act_n;
            snap_valid <= snap;
            if (snap) begin
                snap_acc   <= acc_n;
                snap_count <= count_n;
                snap_act   <= act_n;
            end
        end
    end

    act_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_act (
        .clk            (clk),
        .reset          (reset),
        .flush          (end_flag),
        .in_valid       (snap_valid),
        .in_acc         (snap_acc),
        .in_act         (snap_act),
        .in_count       (snap_count),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .sat_flag       (sat_flag),
        .psum_count     (psum_count)
    );

endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - scoreboard bench for psum_accumulator with a group-level reference model
module tb_psum_accumulator;

`ifdef PSUM_ACCUMULATOR_HSWISH_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        data_valid_in;
    logic [11:0] psum_in;
    logic        last_in;
    logic [11:0] bias_in;
    logic [1:0]  act_sel;
    logic        end_flag;
    logic [11:0] data_out;
    logic        data_valid_out;
    logic        sat_flag;
    logic [7:0]  psum_count;

    psum_accumulator #(
        .DATA_WIDTH (12),
        .FRAC_WIDTH (5),
        .ACC_WIDTH  (20),
        .MAX_PSUMS  (255)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .data_valid_in  (data_valid_in),
        .psum_in        (psum_in),
        .last_in        (last_in),
        .bias_in        (bias_in),
        .act_sel        (act_sel),
        .end_flag       (end_flag),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .sat_flag       (sat_flag),
        .psum_count     (psum_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int d;
        int s;
        int c;
        int due;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    bit     m_active = 1'b0;
    longint m_sum;
    int     m_cnt;
    int     m_act;

    task automatic check(input string name, input int got, input int req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, req, cyc);
        end
    endtask

    // Activation and saturation straight from the arithmetic definition
    function automatic int ref_act(input longint sum, input int a, output int s);
        longint v;
        longint t;
        case (a)
            1: v = (sum < 0) ? 0 : sum;
            2: v = (sum < 0) ? 0 : ((sum > 192) ? 192 : sum);
`ifdef PSUM_ACCUMULATOR_HSWISH_EN
            3: begin
                t = sum + 96;
                if (t < 0) t = 0;
                if (t > 192) t = 192;
                v = (sum * t * 171 + 16384) >>> 15;
            end
`endif
            default: v = sum;
        endcase
        s = 0;
        if (v > 2047) begin
            v = 2047;
            s = 1;
        end else if (v < -2048) begin
            v = -2048;
            s = 1;
        end
        return int'(v);
    endfunction

    task automatic model_beat(input int p, input int b, input int a, input bit l);
        exp_t e;
        int   s;
        if (!m_active) begin
            m_sum    = longint'(b) + longint'(p);
            m_cnt    = 1;
            m_act    = a;
            m_active = 1'b1;
        end else begin
            m_sum += longint'(p);
            m_cnt++;
        end
        if (l || m_cnt == 255) begin
            e.d   = ref_act(m_sum, m_act, s);
            e.s   = s;
            e.c   = m_cnt;
            e.due = cyc + LAT;
            sbq.push_back(e);
            m_active = 1'b0;
        end
    endtask

    task automatic purge_after(input int at);
        m_active = 1'b0;
        while (sbq.size() > 0 && sbq[sbq.size()-1].due > at) sbq.pop_back();
    endtask

    task automatic beat(input int p, input int b, input int a, input bit l);
        data_valid_in = 1'b1;
        psum_in       = 12'(p);
        bias_in       = 12'(b);
        act_sel       = 2'(a);
        last_in       = l;
        model_beat(p, b, a, l);
        @(posedge clk); #1;
        data_valid_in = 1'b0;
        last_in       = 1'b0;
        psum_in       = 12'($urandom);
        bias_in       = 12'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic abort(input bit with_beat);
        end_flag = 1'b1;
        if (with_beat) begin
            data_valid_in = 1'b1;
            last_in       = 1'b1;
            psum_in       = 12'd5;
        end
        purge_after(cyc);
        @(posedge clk); #1;
        end_flag      = 1'b0;
        data_valid_in = 1'b0;
        last_in       = 1'b0;
    endtask

    // Monitor: every pulse must match the oldest pending expectation at its due cycle
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (sbq.size() > 0 && sbq[0].due < cyc) begin
                e = sbq.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missing_pulse: no data_valid_out at cycle %0d, required value %0d", e.due, e.d);
            end
            if (data_valid_out) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: got data_out=%0d at cycle %0d, required no pulse",
                             $signed(data_out), cyc);
                end else begin
                    e = sbq.pop_front();
                    check("data_out", int'($signed(data_out)), e.d);
                    check("sat_flag", int'(sat_flag), e.s);
                    check("psum_count", int'(psum_count), e.c);
                    check("pulse_cycle", cyc, e.due);
                end
            end
        end
    end

    initial begin
        int n, b, a, lo, hi;
        reset         = 1'b1;
        data_valid_in = 1'b0;
        psum_in       = '0;
        last_in       = 1'b0;
        bias_in       = '0;
        act_sel       = '0;
        end_flag      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_data_out", int'(data_out), 0);
        check("reset_valid", int'(data_valid_out), 0);
        check("reset_sat", int'(sat_flag), 0);
        check("reset_count", int'(psum_count), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);

        // Basic sum, bias taken from the first beat only
        beat(64, 32, 0, 0); beat(96, 100, 0, 0); beat(-32, 100, 0, 1); idle(4);
        // ReLU6 clip and ReLU on a negative result
        beat(200, 0, 2, 0); beat(100, 0, 2, 1); idle(1);
        beat(-50, 0, 1, 1); idle(4);
        // Saturation both ways
        beat(2047, 2047, 0, 0); beat(2047, 0, 0, 0); beat(2047, 0, 0, 1); idle(4);
        beat(-2048, -2048, 0, 0); beat(-2048, 0, 0, 0); beat(-2048, 0, 0, 1); idle(4);
        // Back-to-back groups
        beat(3, 1, 0, 0); beat(4, 0, 0, 1); beat(20, 5, 0, 1); beat(-9, 0, 1, 1); idle(4);
        // Forced last at 255 beats, then a fresh group
        for (int i = 0; i < 255; i++) beat(1, 0, 0, 0);
        idle(4);
        beat(7, 0, 0, 1); idle(4);
        // Abort mid-group, then recover
        beat(50, 0, 0, 0); beat(60, 0, 0, 0); abort(0); idle(3);
        beat(10, 0, 0, 1); idle(4);
        // Abort with a result already in flight
        beat(30, 0, 0, 1); abort(0); idle(3);
        beat(31, 0, 0, 1); idle(1); abort(0); idle(3);
        abort(1); idle(3);
        // act_sel=11
        beat(32, 0, 3, 1); idle(3);
        beat(-128, 0, 3, 1); idle(4);
        // Reset mid-group discards it
        beat(100, 0, 0, 0); beat(100, 0, 0, 0);
        reset = 1'b1;
        purge_after(cyc);
        idle(2);
        reset = 1'b0;
        beat(10, 0, 0, 1); idle(4);

        // Randomized groups with bubbles and back-to-back starts
        for (int g = 0; g < 60; g++) begin
            n = $urandom_range(1, 10);
            a = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                lo = -2048; hi = 2047;
            end else begin
                lo = -200; hi = 200;
            end
            b = $urandom_range(0, hi - lo) + lo;
            for (int i = 0; i < n; i++) begin
                beat($urandom_range(0, hi - lo) + lo, b, a, i == n - 1);
                if (i < n - 1) idle($urandom_range(0, 2));
            end
            if ($urandom_range(0, 9) == 0) begin
                abort(0);
            end else begin
                idle($urandom_range(0, 2));
            end
        end

        idle(10);
        check("queue_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, meaning signed Q7.5 word width of partial sums, bias and output.
REQ-002 SHALL have parameter FRAC_WIDTH, default 5, meaning fractional bits.
REQ-003 SHALL have parameter ACC_WIDTH, default 20, meaning accumulator width.
REQ-004 SHALL have parameter MAX_PSUMS, default 255, meaning the maximum number of beats per group.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port data_valid_in, input, 1 bit: psum_in valid; driven by the upstream 32-input adder tree's data_valid_out.
REQ-008 SHALL have port psum_in, input, DATA_WIDTH bits: signed Q7.5 partial sum from the adder tree.
REQ-009 SHALL have port last_in, input, 1 bit: qualified by data_valid_in; marks the final partial sum of the group.
REQ-010 SHALL have port bias_in, input, DATA_WIDTH bits: signed Q7.5 bias, sampled on the group's first beat.
REQ-011 SHALL have port act_sel, input, 2 bits: activation selection (00 none, 01 ReLU, 10 ReLU6, 11 hard-swish), sampled on the group's first beat.
REQ-012 SHALL have port end_flag, input, 1 bit: synchronous abort.
REQ-013 SHALL have port data_out, output, DATA_WIDTH bits: signed Q7.5 activated result.
REQ-014 SHALL have port data_valid_out, output, 1 bit: one-cycle pulse qualifying data_out.
REQ-015 SHALL have port sat_flag, output, 1 bit: data_out was clamped to the signed DATA_WIDTH range.
REQ-016 SHALL have port psum_count, output, 8 bits: number of beats in the reported group.

Function
REQ-017 SHALL implement states IDLE, ACCUM and FINISH.
REQ-018 In IDLE or FINISH, a valid beat SHALL load acc = sext(bias_in) + sext(psum_in), set count=1, latch act_sel, and go to ACCUM, or to FINISH if last_in is set.
REQ-019 In ACCUM, a valid beat SHALL do acc += sext(psum_in) and count++, and go to FINISH on last_in or when count reaches MAX_PSUMS (forced last).
REQ-020 In ACCUM without a valid beat, the block SHALL hold acc and count (bubbles allowed).
REQ-021 FINISH SHALL last exactly one cycle; with no new beat, the next state is IDLE.
REQ-022 On entering FINISH, acc, count and the latched act_sel SHALL be snapshotted into the output stage so back-to-back groups need no gap.
REQ-023 Latency: with the last beat at cycle T, data_valid_out SHALL be high in cycle T+2 only (T+3 when HSWISH_EN is defined, for every act_sel value).
REQ-024 The activation SHALL be applied to acc at full ACC_WIDTH: none = identity; ReLU = max(acc,0); ReLU6 = clamp(acc, 0, 192).
REQ-025 After activation, the result SHALL be clamped to [-2048, 2047]; sat_flag SHALL be 1 only if this clamp altered the value. ReLU6 clipping does not set sat_flag.
REQ-026 ACC_WIDTH SHALL be sized so that MAX_PSUMS full-scale beats plus bias cannot overflow acc; no acc wrap is permitted.
REQ-027 end_flag SHALL take effect at the next edge: state to IDLE, acc and count cleared, the in-flight output stage squashed (no data_valid_out for it), and any beat in the same cycle ignored.
REQ-028 Priority SHALL be reset > end_flag > data_valid_in.
REQ-029 data_out, sat_flag and psum_count SHALL hold their values between pulses.

Reset
REQ-030 On reset, state SHALL go to IDLE and acc, count and pipeline valids SHALL clear.
REQ-031 On reset, data_out, data_valid_out, sat_flag and psum_count SHALL all be 0.
REQ-032 Reset asserted mid-group SHALL discard the group; the first valid beat after reset deasserts starts a new group.

Configuration
REQ-033 With macro PSUM_ACCUMULATOR_HSWISH_EN defined, act_sel=11 SHALL compute t = clamp(acc+96, 0, 192), p = acc*t, and result = (p*171 + 2^14) >>> 15, then saturate per REQ-025, with one extra pipeline register.
REQ-034 Without PSUM_ACCUMULATOR_HSWISH_EN, act_sel=11 SHALL behave as 00, latency SHALL be T+2, and no multiplier SHALL be synthesized.

Structure
REQ-035 Package mnv3_acc_pkg SHALL hold the act_sel encodings, the state enum, and the constants RELU6_MAX=192, HSWISH_OFFSET=96, ONE_SIXTH_Q10=171, and the default widths.
REQ-036 Sub-module act_unit SHALL implement activation and saturation; it contains the optional hard-swish register.

Verification
REQ-037 Bias 32, psums 64, 96, -32 (last on the third), act 00 -> data_out=160, psum_count=3, sat_flag=0, a single valid pulse at T+2.
REQ-038 Bias 0, psums 200, 100 (last), act 10 -> data_out=192, sat_flag=0; single beat -50 (last) with act 01 -> data_out=0.
REQ-039 Bias 2047, three psums of 2047 (last on the third), act 00 -> data_out=2047, sat_flag=1; all -2048 -> data_out=-2048, sat_flag=1.
REQ-040 Group A last beat at T, group B first beat at T+1 (single beat, last) -> two valid pulses at T+2 and T+3 with correct values; 255 beats of 1 with no last and bias 0 -> forced output 255, psum_count=255.
REQ-041 Two beats, then end_flag -> no output; the next group bias 0, psum 10 (last) -> data_out=10.
REQ-042 With HSWISH_EN: bias 0, psum 32 (last), act 11 -> data_out=21 at T+3; psum -128 -> data_out=0.
